// File: rtl/toyrisc_defs.sv
// Shared definitions for the toyrisc execute stage.
// Holds opcode encodings, FSM state encodings, the iteration counter width,
// the iterative-datapath mode type and the single-cycle ALU function.
package toyrisc_defs;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_SLT = 4'd5;
   localparam logic [3:0] OP_SHL = 4'd6;
   localparam logic [3:0] OP_SHR = 4'd7;
   localparam logic [3:0] OP_MUL = 4'd8;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   // Must hold the MUL iteration count of 32.
   localparam int CNT_W = 6;

   typedef enum logic [1:0] {
      IT_SHL = 2'd0,
      IT_SHR = 2'd1,
      IT_MUL = 2'd2
   } iter_mode_e;

   // Single-cycle result; shift opcodes land here only with a zero shift
   // count, where the result is the unshifted left operand.
   function automatic logic [31:0] alu_single(input logic [3:0]  op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
      logic [31:0] r;
      case (op)
         OP_ADD:  r = a + b;
         OP_SUB:  r = a - b;
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_XOR:  r = a ^ b;
         OP_SLT:  r = {31'd0, ($signed(a) < $signed(b))};
         default: r = a;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/execute_unit_iter_core.sv
// iter_core: iterative shift / shift-add multiply datapath.
// Ports:
//   clock_i, rst_n_i   clock and asynchronous active-low reset
//   load_i             capture operands and mode, initialise accumulator
//   step_i             advance one bit (shift by one / one multiplier bit)
//   mode_i             SHL, SHR or MUL, sampled on load
//   a_i, b_i           operands (a: value / multiplicand, b: multiplier)
//   acc_o              accumulator value as it will be after this edge
module iter_core
   import toyrisc_defs::*;
(
   input  logic        clock_i,
   input  logic        rst_n_i,
   input  logic        load_i,
   input  logic        step_i,
   input  iter_mode_e  mode_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [31:0] acc_o
);

   iter_mode_e  mode_q,   mode_d;
   logic [31:0] acc_q,    acc_d;
   logic [31:0] mcand_q,  mcand_d;
   logic [31:0] mplier_q, mplier_d;

   always_comb begin
      mode_d   = mode_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      if (load_i) begin
         mode_d   = mode_i;
         acc_d    = (mode_i == IT_MUL) ? 32'd0 : a_i;
         mcand_d  = a_i;
         mplier_d = b_i;
      end else if (step_i) begin
         case (mode_q)
            IT_SHL: acc_d = acc_q << 1;
            IT_SHR: acc_d = acc_q >> 1;
            IT_MUL: begin
               if (mplier_q[0]) acc_d = acc_q + mcand_q;
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
            end
            default: acc_d = acc_q;
         endcase
      end
   end

   // Exposing the next value lets the parent register the final result on
   // the same edge as the last step.
   assign acc_o = acc_d;

   always_ff @(posedge clock_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         mode_q   <= IT_SHL;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
      end else begin
         mode_q   <= mode_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
      end
   end

endmodule

// File: rtl/execute_unit.sv
// execute_unit: toyrisc execute stage with single-cycle ALU ops and
// iterative SHL/SHR/MUL.
// Ports:
//   clock, reset (async, active-low)
//   start, opcode, leftIn, rightIn, destIn   request and operands
//   result, destAddr, writeEnable            register-file write port
//   done, illegal                            completion pulses
//   busy                                     multi-cycle op in progress
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | accepting start; single-cycle ops complete from here
// RUN     | stepping iter_core, counter counts down to terminal count 1
module execute_unit
   import toyrisc_defs::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  opcode,
   input  logic [31:0] leftIn,
   input  logic [31:0] rightIn,
   input  logic [4:0]  destIn,
   output logic [31:0] result,
   output logic [4:0]  destAddr,
   output logic        writeEnable,
   output logic        done,
   output logic        busy,
   output logic        illegal
);

   logic [0:0]       state_q,  state_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic [31:0]      result_q, result_d;
   logic [4:0]       dest_q,   dest_d;
   logic [4:0]       pend_q,   pend_d;
   logic             we_q,     we_d;
   logic             done_q,   done_d;
   logic             ill_q,    ill_d;

   logic             core_load;
   logic             core_step;
   iter_mode_e       core_mode;
   logic [31:0]      core_acc;
   logic             is_shift;

   iter_core u_iter_core (
      .clock_i (clock),
      .rst_n_i (reset),
      .load_i  (core_load),
      .step_i  (core_step),
      .mode_i  (core_mode),
      .a_i     (leftIn),
      .b_i     (rightIn),
      .acc_o   (core_acc)
   );

   assign is_shift = (opcode == OP_SHL) || (opcode == OP_SHR);

   always_comb begin
      case (opcode)
         OP_MUL:  core_mode = IT_MUL;
         OP_SHR:  core_mode = IT_SHR;
         default: core_mode = IT_SHL;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      result_d  = result_q;
      dest_d    = dest_q;
      pend_d    = pend_q;
      we_d      = 1'b0;
      done_d    = 1'b0;
      ill_d     = 1'b0;
      core_load = 1'b0;
      core_step = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (opcode > OP_MUL) begin
                  result_d = '0;
                  dest_d   = destIn;
                  done_d   = 1'b1;
                  ill_d    = 1'b1;
               end else if (opcode == OP_MUL) begin
                  core_load = 1'b1;
                  cnt_d     = CNT_W'(32);
                  pend_d    = destIn;
                  state_d   = ST_RUN;
               end else if (is_shift && (rightIn[4:0] != 5'd0)) begin
                  core_load = 1'b1;
                  cnt_d     = CNT_W'(rightIn[4:0]);
                  pend_d    = destIn;
                  state_d   = ST_RUN;
               end else begin
                  result_d = alu_single(opcode, leftIn, rightIn);
                  dest_d   = destIn;
                  done_d   = 1'b1;
                  we_d     = 1'b1;
               end
            end
         end
         default: begin
            core_step = 1'b1;
            cnt_d     = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               result_d = core_acc;
               dest_d   = pend_q;
               done_d   = 1'b1;
               we_d     = 1'b1;
               state_d  = ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         result_q <= '0;
         dest_q   <= '0;
         pend_q   <= '0;
         we_q     <= 1'b0;
         done_q   <= 1'b0;
         ill_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         dest_q   <= dest_d;
         pend_q   <= pend_d;
         we_q     <= we_d;
         done_q   <= done_d;
         ill_q    <= ill_d;
      end
   end

   assign result      = result_q;
   assign destAddr    = dest_q;
   assign writeEnable = we_q;
   assign done        = done_q;
   assign illegal     = ill_q;
   assign busy        = (state_q == ST_RUN);

endmodule

// File: tb/tb_execute_unit.sv
module tb_execute_unit;
   import toyrisc_defs::*;

   logic        clock;
   logic        reset;
   logic        start;
   logic [3:0]  opcode;
   logic [31:0] leftIn;
   logic [31:0] rightIn;
   logic [4:0]  destIn;
   logic [31:0] result;
   logic [4:0]  destAddr;
   logic        writeEnable;
   logic        done;
   logic        busy;
   logic        illegal;

   int checks   = 0;
   int failures = 0;

   execute_unit dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .opcode      (opcode),
      .leftIn      (leftIn),
      .rightIn     (rightIn),
      .destIn      (destIn),
      .result      (result),
      .destAddr    (destAddr),
      .writeEnable (writeEnable),
      .done        (done),
      .busy        (busy),
      .illegal     (illegal)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Called just after a rising edge; request is presented for one edge.
   // Returns in the first cycle after acceptance.
   task automatic issue(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] d);
      start   = 1'b1;
      opcode  = op;
      leftIn  = a;
      rightIn = b;
      destIn  = d;
      @(posedge clock); #1;
      start   = 1'b0;
   endtask

   // lat counts cycles from acceptance (1 = first cycle after acceptance).
   task automatic run_to_done(output int lat, output int busy_cnt);
      lat = 1;
      busy_cnt = 0;
      while (done !== 1'b1 && lat < 200) begin
         if (busy === 1'b1) busy_cnt++;
         @(posedge clock); #1;
         lat++;
      end
   endtask

   initial begin
      int lat, bc, done_cnt, we_cnt, done_lat;
      logic [31:0] res_seen;
      logic [4:0]  dest_seen;

      reset = 1'b0; start = 1'b0; opcode = '0;
      leftIn = '0; rightIn = '0; destIn = '0;
      repeat (3) @(posedge clock);
      #1;
      chk ("rst_result",   result, 32'd0);
      chk ("rst_dest",     32'(destAddr), 32'd0);
      chk1("rst_we",       writeEnable, 1'b0);
      chk1("rst_done",     done, 1'b0);
      chk1("rst_busy",     busy, 1'b0);
      chk1("rst_illegal",  illegal, 1'b0);
      reset = 1'b1;

      // First edge after release accepts; then back-to-back SUB while done high.
      issue(OP_ADD, 32'hFFFF_FFFF, 32'd1, 5'd5);
      chk ("add_wrap_result", result, 32'd0);
      chk ("add_wrap_dest",   32'(destAddr), 32'd5);
      chk1("add_wrap_done",   done, 1'b1);
      chk1("add_wrap_we",     writeEnable, 1'b1);
      chk1("add_wrap_busy",   busy, 1'b0);
      chk1("add_wrap_ill",    illegal, 1'b0);
      issue(OP_SUB, 32'd5, 32'd7, 5'd3);
      chk ("sub_b2b_result",  result, 32'hFFFF_FFFE);
      chk ("sub_b2b_dest",    32'(destAddr), 32'd3);
      chk1("sub_b2b_done",    done, 1'b1);
      @(posedge clock); #1;
      chk1("done_pulse",      done, 1'b0);
      chk1("we_pulse",        writeEnable, 1'b0);
      chk ("result_hold",     result, 32'hFFFF_FFFE);

      issue(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd1);
      chk ("and_result", result, 32'hF000_F000);
      issue(OP_OR,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd1);
      chk ("or_result",  result, 32'hFFF0_FFF0);
      issue(OP_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd1);
      chk ("xor_result", result, 32'h0FF0_0FF0);
      issue(OP_SLT, 32'hFFFF_FFFF, 32'd1, 5'd1);
      chk ("slt_neg_result", result, 32'd1);
      issue(OP_SLT, 32'd1, 32'hFFFF_FFFF, 5'd1);
      chk ("slt_pos_result", result, 32'd0);

      // Shift count taken from rightIn[4:0]: 32 means zero shift.
      issue(OP_SHL, 32'h0000_1234, 32'd32, 5'd4);
      chk ("shl0_result", result, 32'h0000_1234);
      chk1("shl0_done",   done, 1'b1);
      chk1("shl0_busy",   busy, 1'b0);
      @(posedge clock); #1;

      issue(OP_SHL, 32'd1, 32'd31, 5'd6);
      run_to_done(lat, bc);
      chk1("shl31_done",   done, 1'b1);
      chk ("shl31_lat",    32'(lat), 32'd32);
      chk ("shl31_busy",   32'(bc), 32'd31);
      chk ("shl31_result", result, 32'h8000_0000);
      chk1("shl31_we",     writeEnable, 1'b1);
      chk ("shl31_dest",   32'(destAddr), 32'd6);
      @(posedge clock); #1;

      issue(OP_SHR, 32'h8000_0000, 32'd4, 5'd9);
      run_to_done(lat, bc);
      chk ("shr4_lat",    32'(lat), 32'd5);
      chk ("shr4_result", result, 32'h0800_0000);
      chk ("shr4_dest",   32'(destAddr), 32'd9);
      @(posedge clock); #1;

      // MUL 7x6 with a stray ADD request while busy.
      issue(OP_MUL, 32'd7, 32'd6, 5'd12);
      done_cnt = 0; done_lat = 0; res_seen = '0; dest_seen = '0;
      for (int c = 1; c <= 40; c++) begin
         if (done === 1'b1) begin
            done_cnt++;
            done_lat  = c;
            res_seen  = result;
            dest_seen = destAddr;
         end
         start   = (c == 5);
         opcode  = OP_ADD;
         leftIn  = 32'd100;
         rightIn = 32'd200;
         destIn  = 5'd7;
         @(posedge clock); #1;
      end
      start = 1'b0;
      chk ("mul_done_count", 32'(done_cnt), 32'd1);
      chk ("mul_lat",        32'(done_lat), 32'd33);
      chk ("mul_result",     res_seen, 32'd42);
      chk ("mul_dest",       32'(dest_seen), 32'd12);
      chk1("mul_idle_after", busy, 1'b0);

      issue(OP_MUL, 32'h0001_0000, 32'h0001_0000, 5'd2);
      run_to_done(lat, bc);
      chk ("mul_ovf_lat",    32'(lat), 32'd33);
      chk ("mul_ovf_result", result, 32'd0);
      @(posedge clock); #1;

      issue(4'hF, 32'd11, 32'd22, 5'd8);
      chk1("ill_done",    done, 1'b1);
      chk1("ill_illegal", illegal, 1'b1);
      chk1("ill_we",      writeEnable, 1'b0);
      chk ("ill_result",  result, 32'd0);
      @(posedge clock); #1;
      chk1("ill_pulse",   illegal, 1'b0);

      // Reset in cycle 10 of a MUL, with a nonzero result held beforehand.
      issue(OP_SUB, 32'd10, 32'd3, 5'd2);
      chk ("sub_pre_rst", result, 32'd7);
      issue(OP_MUL, 32'h0000_FFFF, 32'h0000_FFFF, 5'd13);
      repeat (9) @(posedge clock);
      #1;
      chk1("mid_busy", busy, 1'b1);
      reset = 1'b0;
      #1;
      chk ("arst_result", result, 32'd0);
      chk ("arst_dest",   32'(destAddr), 32'd0);
      chk1("arst_busy",   busy, 1'b0);
      chk1("arst_done",   done, 1'b0);
      chk1("arst_we",     writeEnable, 1'b0);
      chk1("arst_ill",    illegal, 1'b0);
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
      done_cnt = 0; we_cnt = 0;
      for (int c = 0; c < 40; c++) begin
         if (done === 1'b1) done_cnt++;
         if (writeEnable === 1'b1) we_cnt++;
         @(posedge clock); #1;
      end
      chk ("discard_done", 32'(done_cnt), 32'd0);
      chk ("discard_we",   32'(we_cnt), 32'd0);
      issue(OP_ADD, 32'd2, 32'd3, 5'd1);
      chk ("post_rst_add", result, 32'd5);
      chk1("post_rst_done", done, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
